arbitro_mem_datos: RTL and testbench
====================================

ARBITRO_MEM_DATOS -- requirements
Module: arbitro_mem_datos

Interface
REQ-001 Parameter: LATENCIA, 2, memory access cycles (legal 1..8).
REQ-002 Parameter: ANCHO, 32, data/address width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_p0  input  1  pipeline MEM-stage request (priority port, "p0").
REQ-006 escribir_p0  input  1  p0: 1=store, 0=load.
REQ-007 direccion_p0  input  ANCHO  p0 byte address.
REQ-008 dato_escribir_p0  input  ANCHO  p0 store data.
REQ-009 req_p1, escribir_p1, direccion_p1, dato_escribir_p1  input  1/1/ANCHO/ANCHO  secondary requester (DMA/debug), same meaning.
REQ-010 ack_p0, ack_p1  output  1 each  one-cycle completion pulse.
REQ-011 dato_leido  output  ANCHO  registered load data, valid while ack_p0 or ack_p1 is high.
REQ-012 stall_MEM  output  1  pipeline freeze request.
REQ-013 mem_escribir, mem_leer  output  1 each  strobes to data memory.
REQ-014 mem_direccion, mem_dato_escribir  output  ANCHO each  registered address/data to data memory.
REQ-015 mem_dato_leer  input  ANCHO  memory read data, valid in the last ESPERA cycle.

Function
REQ-016 FSM states SHALL be REPOSO, ESPERA, FIN; encoding free.
REQ-017 In REPOSO with any req high, the block SHALL grant at the edge, latch the granted port's escribir/direccion/dato_escribir into internal registers, and enter ESPERA.
REQ-018 Arbitration SHALL be round-robin via register ultimo (last granted port): single requester wins; both requesting -> the port != ultimo wins; ultimo updates on each grant.
REQ-019 ESPERA SHALL last exactly LATENCIA cycles, counted by a counter cleared on grant.
REQ-020 mem_direccion/mem_dato_escribir SHALL hold the latched values throughout ESPERA and are don't-care elsewhere (held, not cleared).
REQ-021 Load: mem_leer SHALL be high for every ESPERA cycle; mem_dato_leer SHALL be captured into dato_leido at the edge leaving ESPERA.
REQ-022 Store: mem_escribir SHALL be high only in the first ESPERA cycle; mem_leer low; dato_leido unchanged.
REQ-023 FIN SHALL last one cycle with ack of the granted port high, then return to REPOSO; ack of the other port stays low.
REQ-024 Request-to-ack latency SHALL be LATENCIA+1 cycles after the grant edge; minimum spacing between grants is LATENCIA+2 cycles.
REQ-025 Requester SHALL hold req and operands stable until it samples ack high and SHALL drop req at that edge; req still high in REPOSO starts a new access.
REQ-026 Requests arriving during ESPERA/FIN SHALL wait; no request is lost or reordered within a port.
REQ-027 stall_MEM SHALL equal req_p0 AND NOT ack_p0 (combinational).
REQ-028 req changes from either port during ESPERA/FIN SHALL not affect the in-flight access.

Reset
REQ-029 rst_n low SHALL asynchronously force: state REPOSO, counter 0, ultimo=p1 (so p0 wins first tie), ack_p0=ack_p1=0, mem_leer=mem_escribir=0, dato_leido=0, mem_direccion=0, mem_dato_escribir=0.
REQ-030 Reset mid-access SHALL abort it with no ack and no further write strobe; first access after release restarts arbitration.
REQ-031 stall_MEM during reset SHALL follow REQ-027 (equals req_p0).

Verification
REQ-032 LATENCIA=2, p0 load addr 0x10, memory returns 0xDEADBEEF -> mem_leer high 2 cycles, ack_p0 on 3rd cycle after grant, dato_leido=0xDEADBEEF, stall_MEM high until ack.
REQ-033 p1 store addr 0x20 data 0x12345678 -> mem_escribir high exactly 1 cycle with those values, ack_p1 1 cycle, dato_leido unchanged.
REQ-034 Both requesting continuously from reset -> grants p0,p1,p0,p1; each ack spaced LATENCIA+2=4 cycles.
REQ-035 rst_n low in 2nd ESPERA cycle of a load -> mem_leer drops immediately, no ack, dato_leido=0; after release pending p0 served normally.
REQ-036 LATENCIA=1 and LATENCIA=8 back-to-back p0 loads -> latency 2 and 9 cycles respectively, no lost requests.
REQ-037 p1 granted, p0 raises req in ESPERA -> stall_MEM high, p0 granted in next REPOSO, p1 data unaffected.

Source files
------------

// File: rtl/arbitro_mem_datos.sv
// arbitro_mem_datos: round-robin arbiter giving two requesters access to one fixed-latency data memory
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_p0 / req_p1                  access requests (p0 = pipeline MEM stage, p1 = DMA/debug)
//   escribir_pX                      1 = store, 0 = load
//   direccion_pX, dato_escribir_pX   byte address and store data of each port
//   ack_p0 / ack_p1                  one-cycle completion pulse to the granted port
//   dato_leido                       registered load data, valid while an ack is high
//   stall_MEM                        pipeline freeze while p0 waits for its ack
//   mem_escribir, mem_leer           strobes to the data memory
//   mem_direccion, mem_dato_escribir address/data latched at grant time
//   mem_dato_leer                    memory read data, valid in the last wait cycle
module arbitro_mem_datos #(
    parameter int LATENCIA = 2,
    parameter int ANCHO    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_p0,
    input  logic             escribir_p0,
    input  logic [ANCHO-1:0] direccion_p0,
    input  logic [ANCHO-1:0] dato_escribir_p0,
    input  logic             req_p1,
    input  logic             escribir_p1,
    input  logic [ANCHO-1:0] direccion_p1,
    input  logic [ANCHO-1:0] dato_escribir_p1,
    output logic             ack_p0,
    output logic             ack_p1,
    output logic [ANCHO-1:0] dato_leido,
    output logic             stall_MEM,
    output logic             mem_escribir,
    output logic             mem_leer,
    output logic [ANCHO-1:0] mem_direccion,
    output logic [ANCHO-1:0] mem_dato_escribir,
    input  logic [ANCHO-1:0] mem_dato_leer
);

    if (LATENCIA < 1 || LATENCIA > 8) begin : g_chk_latencia
        $error("LATENCIA must be in 1..8");
    end

    typedef enum logic [1:0] {REPOSO, ESPERA, FIN} estado_t;

    localparam logic [3:0] CNT_ULT = 4'(LATENCIA - 1);

    estado_t          estado_q, estado_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ultimo_q, ultimo_d;
    logic             puerto_q, puerto_d;
    logic             esc_q, esc_d;
    logic [ANCHO-1:0] dir_q, dir_d;
    logic [ANCHO-1:0] dat_q, dat_d;
    logic [ANCHO-1:0] leido_q, leido_d;
    logic             sel_p1;

    // p1 wins when it is alone, or on a tie when p0 was served last
    assign sel_p1 = req_p1 && (!req_p0 || !ultimo_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            ultimo_q <= 1'b1;
            puerto_q <= 1'b0;
            esc_q    <= 1'b0;
            dir_q    <= '0;
            dat_q    <= '0;
            leido_q  <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            ultimo_q <= ultimo_d;
            puerto_q <= puerto_d;
            esc_q    <= esc_d;
            dir_q    <= dir_d;
            dat_q    <= dat_d;
            leido_q  <= leido_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        ultimo_d = ultimo_q;
        puerto_d = puerto_q;
        esc_d    = esc_q;
        dir_d    = dir_q;
        dat_d    = dat_q;
        leido_d  = leido_q;
        unique case (estado_q)
            REPOSO: begin
                if (req_p0 || req_p1) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                    ultimo_d = sel_p1;
                    puerto_d = sel_p1;
                    esc_d    = sel_p1 ? escribir_p1 : escribir_p0;
                    dir_d    = sel_p1 ? direccion_p1 : direccion_p0;
                    dat_d    = sel_p1 ? dato_escribir_p1 : dato_escribir_p0;
                end
            end
            ESPERA: begin
                if (cnt_q == CNT_ULT) begin
                    estado_d = FIN;
                    leido_d  = esc_q ? leido_q : mem_dato_leer;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FIN:     estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    // strobes and acks decode straight from registered state, so reset drops them at once
    assign mem_leer          = (estado_q == ESPERA) && !esc_q;
    assign mem_escribir      = (estado_q == ESPERA) && esc_q && (cnt_q == 4'd0);
    assign ack_p0            = (estado_q == FIN) && !puerto_q;
    assign ack_p1            = (estado_q == FIN) && puerto_q;
    assign stall_MEM         = req_p0 && !ack_p0;
    assign mem_direccion     = dir_q;
    assign mem_dato_escribir = dat_q;
    assign dato_leido        = leido_q;

endmodule

// File: tb/tb_arbitro_mem_datos.sv
// tb_arbitro_mem_datos: self-checking bench for arbitro_mem_datos
module tb_arbitro_mem_datos;

    localparam int LAT = 2;

    typedef struct {
        logic        port;
        logic        esc;
        logic [31:0] dir;
        logic [31:0] dat;
        logic [31:0] exp;
    } op_t;

    logic        clk, rst_n;
    logic        req_p0, escribir_p0, req_p1, escribir_p1;
    logic [31:0] direccion_p0, dato_escribir_p0, direccion_p1, dato_escribir_p1;
    logic        ack_p0, ack_p1, stall_MEM, mem_escribir, mem_leer;
    logic [31:0] dato_leido, mem_direccion, mem_dato_escribir, mem_dato_leer;

    logic [31:0] mem [16] = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                              32'hDEADBEEF, 32'h10000005, 32'h10000006, 32'h10000007,
                              32'h10000008, 32'h10000009, 32'h1000000A, 32'h1000000B,
                              32'h1000000C, 32'h1000000D, 32'h1000000E, 32'h1000000F};

    logic        l1_req, l8_req, cero;
    logic [31:0] l1_dir, l8_dir, cero_w;
    logic        l1_ack0, l1_ack1, l1_stall, l1_mw, l1_mr;
    logic        l8_ack0, l8_ack1, l8_stall, l8_mw, l8_mr;
    logic [31:0] l1_leido, l1_mdir, l1_mdat, l8_leido, l8_mdir, l8_mdat;

    op_t sb[$];
    op_t tabla[10];
    int  errors = 0, n_chk = 0;
    int  n_rd = 0, n_wr = 0;

    arbitro_mem_datos #(.LATENCIA(LAT), .ANCHO(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_p0(req_p0), .escribir_p0(escribir_p0), .direccion_p0(direccion_p0), .dato_escribir_p0(dato_escribir_p0),
        .req_p1(req_p1), .escribir_p1(escribir_p1), .direccion_p1(direccion_p1), .dato_escribir_p1(dato_escribir_p1),
        .ack_p0(ack_p0), .ack_p1(ack_p1), .dato_leido(dato_leido), .stall_MEM(stall_MEM),
        .mem_escribir(mem_escribir), .mem_leer(mem_leer), .mem_direccion(mem_direccion),
        .mem_dato_escribir(mem_dato_escribir), .mem_dato_leer(mem_dato_leer)
    );

    arbitro_mem_datos #(.LATENCIA(1), .ANCHO(32)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_p0(l1_req), .escribir_p0(cero), .direccion_p0(l1_dir), .dato_escribir_p0(cero_w),
        .req_p1(cero), .escribir_p1(cero), .direccion_p1(cero_w), .dato_escribir_p1(cero_w),
        .ack_p0(l1_ack0), .ack_p1(l1_ack1), .dato_leido(l1_leido), .stall_MEM(l1_stall),
        .mem_escribir(l1_mw), .mem_leer(l1_mr), .mem_direccion(l1_mdir),
        .mem_dato_escribir(l1_mdat), .mem_dato_leer(~l1_mdir)
    );

    arbitro_mem_datos #(.LATENCIA(8), .ANCHO(32)) u_l8 (
        .clk(clk), .rst_n(rst_n),
        .req_p0(l8_req), .escribir_p0(cero), .direccion_p0(l8_dir), .dato_escribir_p0(cero_w),
        .req_p1(cero), .escribir_p1(cero), .direccion_p1(cero_w), .dato_escribir_p1(cero_w),
        .ack_p0(l8_ack0), .ack_p1(l8_ack1), .dato_leido(l8_leido), .stall_MEM(l8_stall),
        .mem_escribir(l8_mw), .mem_leer(l8_mr), .mem_direccion(l8_mdir),
        .mem_dato_escribir(l8_mdat), .mem_dato_leer(~l8_mdir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dato_leer = mem[mem_direccion[5:2]];

    always @(posedge clk)
        if (mem_escribir) mem[mem_direccion[5:2]] <= mem_dato_escribir;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic p, input logic r, input logic e, input logic [31:0] d, input logic [31:0] w);
        if (p) begin
            req_p1 = r; escribir_p1 = e; direccion_p1 = d; dato_escribir_p1 = w;
        end else begin
            req_p0 = r; escribir_p0 = e; direccion_p0 = d; dato_escribir_p0 = w;
        end
    endtask

    // single access from an idle arbiter: expected result goes to the scoreboard when driven
    task automatic do_op(input op_t v);
        int  c;
        logic got;
        @(negedge clk);
        drive(v.port, 1'b1, v.esc, v.dir, v.dat);
        sb.push_back(v);
        c = 0;
        got = 1'b0;
        while (!got && c < 30) begin
            @(negedge clk);
            c++;
            got = v.port ? ack_p1 : ack_p0;
        end
        chk("latencia", 32'(c), 32'(LAT + 1));
        drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // scoreboard: strobes are checked against the in-flight head, acks pop and compare
    always @(negedge clk) begin
        if (!rst_n) begin
            n_rd = 0;
            n_wr = 0;
        end else begin
            if (mem_leer) begin
                n_rd++;
                if (sb.size() > 0) chk("rd_dir", mem_direccion, sb[0].dir);
            end
            if (mem_escribir) begin
                n_wr++;
                if (sb.size() > 0) begin
                    chk("wr_dir", mem_direccion, sb[0].dir);
                    chk("wr_dat", mem_dato_escribir, sb[0].dat);
                end
            end
            if (ack_p0 || ack_p1) begin
                if (sb.size() == 0) begin
                    chk("ack_spurious", 32'({ack_p0, ack_p1}), 32'h0);
                end else begin
                    op_t e;
                    e = sb.pop_front();
                    chk("ack_port", 32'({ack_p0, ack_p1}), e.port ? 32'h1 : 32'h2);
                    chk("dato_leido", dato_leido, e.exp);
                    chk("n_rd", 32'(n_rd), e.esc ? 32'h0 : 32'(LAT));
                    chk("n_wr", 32'(n_wr), e.esc ? 32'h1 : 32'h0);
                end
                n_rd = 0;
                n_wr = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog errors=%0d checks=%0d", errors, n_chk);
        $fatal(1);
    end

    initial begin
        int c, na, tprev, n1, n8, t1, t8;
        tabla[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
        tabla[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF};
        tabla[2] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678};
        tabla[3] = '{1'b1, 1'b0, 32'h04, 32'h0,        32'h10000001};
        tabla[4] = '{1'b0, 1'b1, 32'h3C, 32'hAABBCCDD, 32'h10000001};
        tabla[5] = '{1'b1, 1'b0, 32'h3C, 32'h0,        32'hAABBCCDD};
        tabla[6] = '{1'b0, 1'b0, 32'h00, 32'h0,        32'h10000000};
        tabla[7] = '{1'b1, 1'b1, 32'h00, 32'hFFFFFFFF, 32'h10000000};
        tabla[8] = '{1'b0, 1'b0, 32'h00, 32'h0,        32'hFFFFFFFF};
        tabla[9] = '{1'b1, 1'b0, 32'h08, 32'h0,        32'h10000002};

        cero = 1'b0; cero_w = 32'h0;
        l1_req = 1'b0; l8_req = 1'b0; l1_dir = 32'h0; l8_dir = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        req_p0 = 1'b1;
        #12;
        chk("rst_stall", 32'(stall_MEM), 32'h1);
        chk("rst_ack", 32'({ack_p0, ack_p1}), 32'h0);
        chk("rst_strobes", 32'({mem_leer, mem_escribir}), 32'h0);
        chk("rst_leido", dato_leido, 32'h0);
        chk("rst_mdir", mem_direccion, 32'h0);
        chk("rst_mdat", mem_dato_escribir, 32'h0);
        req_p0 = 1'b0;
        #1 chk("rst_stall_low", 32'(stall_MEM), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) do_op(tabla[i]);

        // reset, then both ports request continuously: p0 wins first, then alternate
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst2_leido", dato_leido, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h04, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
        sb.push_back('{1'b0, 1'b0, 32'h04, 32'h0, 32'h10000001});
        sb.push_back('{1'b1, 1'b0, 32'h08, 32'h0, 32'h10000002});
        sb.push_back('{1'b0, 1'b0, 32'h04, 32'h0, 32'h10000001});
        sb.push_back('{1'b1, 1'b0, 32'h08, 32'h0, 32'h10000002});
        na = 0; tprev = 0; c = 0;
        while (na < 4 && c < 40) begin
            @(negedge clk);
            c++;
            if (ack_p0 || ack_p1) begin
                na++;
                if (na == 1) chk("rr_first", 32'(c), 32'(LAT + 1));
                else chk("rr_spacing", 32'(c - tprev), 32'(LAT + 2));
                tprev = c;
            end
        end
        chk("rr_acks", 32'(na), 32'h4);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // reset during the second wait cycle of a load aborts it; p0 keeps requesting
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_leer_before", 32'(mem_leer), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_leer", 32'(mem_leer), 32'h0);
        chk("abort_ack", 32'({ack_p0, ack_p1}), 32'h0);
        chk("abort_leido", dato_leido, 32'h0);
        chk("abort_stall", 32'(stall_MEM), 32'h1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        sb.push_back('{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF});
        c = 0;
        while (!ack_p0 && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("abort_retry_lat", 32'(c), 32'(LAT + 1));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // p1 in flight, p0 arrives during the wait and is served next
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
        sb.push_back('{1'b1, 1'b0, 32'h08, 32'h0, 32'h10000002});
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h3C, 32'h0);
        sb.push_back('{1'b0, 1'b0, 32'h3C, 32'h0, 32'hAABBCCDD});
        #1 chk("late_stall", 32'(stall_MEM), 32'h1);
        c = 1; t1 = 0; t8 = 0;
        while (t8 == 0 && c < 30) begin
            @(negedge clk);
            c++;
            if (ack_p1) begin
                t1 = c;
                #1 chk("late_stall_p1ack", 32'(stall_MEM), 32'h1);
                drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (ack_p0) begin
                t8 = c;
                #1 chk("late_stall_p0ack", 32'(stall_MEM), 32'h0);
                drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        chk("late_p1_time", 32'(t1), 32'(LAT + 1));
        chk("late_p0_time", 32'(t8), 32'(2 * LAT + 3));

        // back-to-back p0 loads on the LATENCIA=1 and LATENCIA=8 instances
        @(negedge clk);
        l1_req = 1'b1; l8_req = 1'b1; l1_dir = 32'h100; l8_dir = 32'h100;
        n1 = 0; n8 = 0; t1 = 0; t8 = 0;
        for (int k = 1; k <= 60 && (n1 < 3 || n8 < 3); k++) begin
            @(negedge clk);
            if (l1_ack0) begin
                n1++;
                chk("l1_dato", l1_leido, ~l1_dir);
                chk("l1_lat", 32'(k - t1), n1 == 1 ? 32'd2 : 32'd3);
                t1 = k;
                l1_dir = l1_dir + 32'h100;
                if (n1 == 3) l1_req = 1'b0;
            end
            if (l8_ack0) begin
                n8++;
                chk("l8_dato", l8_leido, ~l8_dir);
                chk("l8_lat", 32'(k - t8), n8 == 1 ? 32'd9 : 32'd10);
                t8 = k;
                l8_dir = l8_dir + 32'h100;
                if (n8 == 3) l8_req = 1'b0;
            end
        end
        chk("l1_acks", 32'(n1), 32'h3);
        chk("l8_acks", 32'(n8), 32'h3);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, n_chk);
        $finish;
    end

endmodule
